ifetch_buf: RTL and testbench



---
 rtl/ifetch_buf_pkg.sv | 13 +
 rtl/ifetch_buf.sv | 107 ++++++++++
 tb/tb_ifetch_buf.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_buf_pkg.sv
// Shared definitions for the instruction prefetch buffer.
package ifetch_buf_pkg;

  // Instruction returned to the datapath whenever the fetch stalls.
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_FILL
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_buf.sv
// Single-line instruction prefetch buffer: combinational hit path, burst refill on miss.
module ifetch_buf
  import ifetch_buf_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] ins,
  output logic        if_stall,
  input  logic        inv,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned WIDX  = $clog2(LINE_WORDS);
  localparam int unsigned OFS_W = WIDX + 2;
  localparam int unsigned TAG_W = 32 - OFS_W;
  localparam logic [WIDX-1:0] LAST_BEAT = WIDX'(LINE_WORDS - 1);

  ifetch_state_t    state_q;
  logic [31:0]      line_q [LINE_WORDS];
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] tag_pend_q;
  logic             valid_q;
  logic             drop_q;
  logic [WIDX-1:0]  cnt_q;
  logic             bus_req_q;
  logic [31:0]      bus_addr_q;

  logic [TAG_W-1:0] pc_tag_c;
  logic [WIDX-1:0]  pc_word_c;
  logic             hit_c;
  logic             unused_c;

  // Address split and hit detection; byte offset within a word is don't-care.
  assign pc_tag_c  = pc[31:OFS_W];
  assign pc_word_c = pc[OFS_W-1:2];
  assign unused_c  = ^pc[1:0];
  assign hit_c     = valid_q && (tag_q == pc_tag_c) && (state_q == IF_IDLE);

  assign ins      = hit_c ? line_q[pc_word_c] : NOP;
  assign if_stall = !hit_c;
  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;

  // Refill FSM: miss -> request burst -> collect beats -> revalidate unless invalidated meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IF_IDLE;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      tag_q      <= '0;
      tag_pend_q <= '0;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (!hit_c) begin
            state_q    <= IF_REQ;
            bus_req_q  <= 1'b1;
            bus_addr_q <= {pc_tag_c, OFS_W'(0)};
            tag_pend_q <= pc_tag_c;
            valid_q    <= 1'b0;
          end else if (inv) begin
            valid_q <= 1'b0;
          end
        end
        IF_REQ: begin
          if (inv) drop_q <= 1'b1;
          if (bus_gnt) begin
            state_q   <= IF_FILL;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        IF_FILL: begin
          if (inv) drop_q <= 1'b1;
          if (bus_rvalid) begin
            cnt_q <= cnt_q + WIDX'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q <= IF_IDLE;
              tag_q   <= tag_pend_q;
              valid_q <= !drop_q && !inv;
              drop_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IF_IDLE;
      endcase
    end
  end

  // Line storage: beats land only while filling; stray beats elsewhere are ignored.
  always_ff @(posedge clk) begin
    if (state_q == IF_FILL && bus_rvalid) begin
      line_q[cnt_q] <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: directed vector table, reset-mid-burst sequence, randomized run vs. transaction model.
module tb_ifetch_buf;

  localparam int unsigned LW    = 4;
  localparam logic [31:0] NOPV  = 32'h0000_0000;
  localparam int unsigned LBYTE = LW * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        if_stall;
  logic        inv;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_buf #(.LINE_WORDS(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .ins       (ins),
    .if_stall  (if_stall),
    .inv       (inv),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] pc;
    logic        inv;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] ins;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [31:0] p, input logic i, input logic g, input logic r,
                              input logic [31:0] d, input logic st, input logic [31:0] in_e,
                              input logic rq, input logic [31:0] ad);
    vec_t v;
    v.pc = p; v.inv = i; v.gnt = g; v.rv = r; v.rdata = d;
    v.stall = st; v.ins = in_e; v.req = rq; v.addr = ad;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic st, input logic [31:0] in_e,
                         input logic rq, input logic [31:0] ad);
    check({tag, " if_stall"}, 32'(if_stall), 32'(st));
    check({tag, " ins"},      ins,           in_e);
    check({tag, " bus_req"},  32'(bus_req),  32'(rq));
    check({tag, " bus_addr"}, bus_addr,      ad);
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle before the next rising edge.
  task automatic drive(input logic [31:0] p, input logic i, input logic g, input logic r,
                       input logic [31:0] d);
    @(negedge clk);
    pc = p; inv = i; bus_gnt = g; bus_rvalid = r; bus_rdata = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pc = '0; inv = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference memory seen by the random slave.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return (a / LBYTE) * LBYTE;
  endfunction

  // Transaction-level model state for the random run.
  logic        m_valid, m_busy, m_drop, s_granted;
  logic [31:0] m_base, m_req_base, rpc;
  int          s_wait, s_beat, stall_run;
  logic        last_stall, exp_hit;

  initial begin
    rst_n = 1'b0;
    pc = '0; inv = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    // Directed vector table starting from reset.
    add(32'h00, 0, 0, 0, 32'h0,    1, NOPV, 0, 32'h00);
    add(32'h00, 0, 1, 0, 32'h0,    1, NOPV, 1, 32'h00);
    add(32'h00, 0, 0, 1, 32'hA0,   1, NOPV, 0, 32'h00);
    add(32'h00, 0, 0, 1, 32'hA1,   1, NOPV, 0, 32'h00);
    add(32'h00, 0, 0, 1, 32'hA2,   1, NOPV, 0, 32'h00);
    add(32'h00, 0, 0, 1, 32'hA3,   1, NOPV, 0, 32'h00);
    add(32'h00, 0, 0, 0, 32'h0,    0, 32'hA0, 0, 32'h00);
    add(32'h04, 0, 0, 0, 32'h0,    0, 32'hA1, 0, 32'h00);
    add(32'h08, 0, 0, 0, 32'h0,    0, 32'hA2, 0, 32'h00);
    add(32'h0C, 0, 0, 0, 32'h0,    0, 32'hA3, 0, 32'h00);
    add(32'h10, 0, 0, 0, 32'h0,    1, NOPV, 0, 32'h00);
    add(32'h10, 0, 0, 0, 32'h0,    1, NOPV, 1, 32'h10);
    add(32'h10, 0, 0, 0, 32'h0,    1, NOPV, 1, 32'h10);
    add(32'h10, 0, 0, 0, 32'h0,    1, NOPV, 1, 32'h10);
    add(32'h10, 0, 1, 0, 32'h0,    1, NOPV, 1, 32'h10);
    add(32'h10, 0, 0, 1, 32'hB0,   1, NOPV, 0, 32'h10);
    add(32'h10, 0, 0, 0, 32'h0,    1, NOPV, 0, 32'h10);
    add(32'h10, 0, 0, 1, 32'hB1,   1, NOPV, 0, 32'h10);
    add(32'h10, 0, 0, 1, 32'hB2,   1, NOPV, 0, 32'h10);
    add(32'h10, 0, 0, 0, 32'h0,    1, NOPV, 0, 32'h10);
    add(32'h10, 0, 0, 1, 32'hB3,   1, NOPV, 0, 32'h10);
    add(32'h10, 0, 0, 0, 32'h0,    0, 32'hB0, 0, 32'h10);
    add(32'h14, 0, 0, 0, 32'h0,    0, 32'hB1, 0, 32'h10);
    add(32'h18, 0, 0, 0, 32'h0,    0, 32'hB2, 0, 32'h10);
    add(32'h1C, 0, 0, 0, 32'h0,    0, 32'hB3, 0, 32'h10);
    add(32'h1C, 0, 0, 1, 32'hDEAD, 0, 32'hB3, 0, 32'h10);
    add(32'h10, 0, 0, 1, 32'hDEAD, 0, 32'hB0, 0, 32'h10);
    add(32'h20, 0, 0, 0, 32'h0,    1, NOPV, 0, 32'h10);
    add(32'h20, 0, 1, 0, 32'h0,    1, NOPV, 1, 32'h20);
    add(32'h20, 0, 0, 1, 32'hC0,   1, NOPV, 0, 32'h20);
    add(32'h20, 1, 0, 1, 32'hC1,   1, NOPV, 0, 32'h20);
    add(32'h20, 0, 0, 1, 32'hC2,   1, NOPV, 0, 32'h20);
    add(32'h20, 0, 0, 1, 32'hC3,   1, NOPV, 0, 32'h20);
    add(32'h20, 0, 0, 0, 32'h0,    1, NOPV, 0, 32'h20);
    add(32'h20, 0, 1, 0, 32'h0,    1, NOPV, 1, 32'h20);
    add(32'h20, 0, 0, 1, 32'hD0,   1, NOPV, 0, 32'h20);
    add(32'h20, 0, 0, 1, 32'hD1,   1, NOPV, 0, 32'h20);
    add(32'h20, 0, 0, 1, 32'hD2,   1, NOPV, 0, 32'h20);
    add(32'h20, 0, 0, 1, 32'hD3,   1, NOPV, 0, 32'h20);
    add(32'h20, 0, 0, 0, 32'h0,    0, 32'hD0, 0, 32'h20);
    add(32'h24, 0, 0, 0, 32'h0,    0, 32'hD1, 0, 32'h20);
    add(32'h2E, 0, 0, 0, 32'h0,    0, 32'hD3, 0, 32'h20);

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk_out("in_reset", 1'b1, NOPV, 1'b0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].pc, vecs[k].inv, vecs[k].gnt, vecs[k].rv, vecs[k].rdata);
      chk_out($sformatf("vec%0d", k), vecs[k].stall, vecs[k].ins, vecs[k].req, vecs[k].addr);
    end

    // Reset asserted in the middle of a burst, trailing beats keep arriving.
    drive(32'h40, 0, 0, 0, 32'h0);   chk_out("rm_miss", 1, NOPV, 0, 32'h20);
    drive(32'h40, 0, 1, 0, 32'h0);   chk_out("rm_req",  1, NOPV, 1, 32'h40);
    drive(32'h40, 0, 0, 1, 32'hE0);  chk_out("rm_b0",   1, NOPV, 0, 32'h40);
    drive(32'h40, 0, 0, 1, 32'hE1);  chk_out("rm_b1",   1, NOPV, 0, 32'h40);
    drive(32'h40, 0, 0, 1, 32'hE2);
    rst_n = 1'b0;
    #1;
    chk_out("rm_rst", 1, NOPV, 0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(32'h40, 0, 0, 1, 32'hE3);  chk_out("rm_idle", 1, NOPV, 0, 32'h0);
    drive(32'h40, 0, 0, 1, 32'hEEEE); chk_out("rm_req2", 1, NOPV, 1, 32'h40);
    drive(32'h40, 0, 1, 0, 32'h0);   chk_out("rm_gnt2", 1, NOPV, 1, 32'h40);
    drive(32'h40, 0, 0, 1, 32'hF0);  chk_out("rm_f0",   1, NOPV, 0, 32'h40);
    drive(32'h40, 0, 0, 1, 32'hF1);  chk_out("rm_f1",   1, NOPV, 0, 32'h40);
    drive(32'h40, 0, 0, 1, 32'hF2);  chk_out("rm_f2",   1, NOPV, 0, 32'h40);
    drive(32'h40, 0, 0, 1, 32'hF3);  chk_out("rm_f3",   1, NOPV, 0, 32'h40);
    drive(32'h40, 0, 0, 0, 32'h0);   chk_out("rm_hit0", 0, 32'hF0, 0, 32'h40);
    drive(32'h4C, 0, 0, 0, 32'h0);   chk_out("rm_hit3", 0, 32'hF3, 0, 32'h40);

    // Randomized run against the transaction-level model.
    do_reset();
    m_valid = 0; m_busy = 0; m_drop = 0; s_granted = 0;
    m_base = '0; m_req_base = '0; rpc = '0;
    s_wait = 0; s_beat = 0; stall_run = 0; last_stall = 1;
    for (int c = 0; c < 3000; c++) begin
      logic g, r, iv;
      logic [31:0] d;
      if (!last_stall) begin
        if ($urandom_range(0, 9) < 7) rpc = (rpc + 32'd4) & 32'hFF;
        else rpc = 32'($urandom_range(0, 255));
      end else if ($urandom_range(0, 19) == 0) begin
        rpc = 32'($urandom_range(0, 255));
      end
      iv = ($urandom_range(0, 29) == 0);
      g = 1'b0; r = 1'b0; d = $urandom;
      if (m_busy && !s_granted) begin
        if (s_wait == 0) g = 1'b1;
        else s_wait--;
      end else if (m_busy && s_granted) begin
        r = ($urandom_range(0, 2) != 0);
        d = mem(m_req_base + 32'(4 * s_beat));
      end
      if (!(m_busy && s_granted) && !g) r = ($urandom_range(0, 4) == 0);

      drive(rpc, iv, g, r, d);

      exp_hit = m_valid && (m_base == base_of(rpc)) && !m_busy;
      check("rnd if_stall", 32'(if_stall), 32'(!exp_hit));
      check("rnd ins", ins, exp_hit ? mem(rpc & ~32'h3) : NOPV);
      check("rnd bus_req", 32'(bus_req), 32'(m_busy && !s_granted));
      if (m_busy) check("rnd bus_addr", bus_addr, m_req_base);

      if (if_stall) stall_run++;
      else stall_run = 0;
      if (stall_run > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd stall_bound: stalled %0d cycles, limit 200", stall_run);
        break;
      end

      if (!m_busy) begin
        if (!exp_hit) begin
          m_busy = 1; m_valid = 0; m_drop = 0; m_req_base = base_of(rpc);
          s_granted = 0; s_beat = 0; s_wait = $urandom_range(0, 3);
        end else if (iv) begin
          m_valid = 0;
        end
      end else begin
        if (iv) m_drop = 1;
        if (g) begin
          s_granted = 1;
        end else if (s_granted && r) begin
          s_beat++;
          if (s_beat == LW) begin
            m_busy = 0; m_valid = !m_drop; m_base = m_req_base; m_drop = 0;
          end
        end
      end
      last_stall = !exp_hit;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
